// File: rtl/day01_loader_if.sv
// day01_loader_if: byte-stream input, memory write port and status bundle
// for the day 1 loader. The checksum signal exists only when
// DAY01_LOADER_CHECKSUM_EN is defined.
interface day01_loader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [ADDR_W-1:0] count;
  logic              done;
  logic              error;
`ifdef DAY01_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  // Producer side: drives the byte stream, observes memory writes and status.
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, mem_we, mem_addr, mem_wdata, count, done, error
`ifdef DAY01_LOADER_CHECKSUM_EN
    , input checksum
`endif
  );

  // Loader side: consumes the byte stream, drives memory writes and status.
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, mem_we, mem_addr, mem_wdata, count, done, error
`ifdef DAY01_LOADER_CHECKSUM_EN
    , output checksum
`endif
  );
endinterface

// File: rtl/day01_loader.sv
// day01_loader: parses a stream of ASCII lines such as "+13" / "-7" into
// signed DATA_W-bit values and writes them to consecutive memory addresses.
// Define DAY01_LOADER_CHECKSUM_EN to add a running signed sum of all
// written values on bus.checksum.
module day01_loader #(
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 64,
  parameter int MAX_ENTRIES = 1024
) (
  input logic          clk,
  input logic          rst_n,
  day01_loader_if.slave bus
);

  localparam logic [7:0] LP_PLUS  = 8'h2B;
  localparam logic [7:0] LP_MINUS = 8'h2D;
  localparam logic [7:0] LP_NL    = 8'h0A;
  localparam logic [7:0] LP_CR    = 8'h0D;
  localparam logic [7:0] LP_ZERO  = 8'h30;
  localparam logic [7:0] LP_NINE  = 8'h39;
  // One extra bit so a capacity of exactly 2^ADDR_W is representable.
  localparam logic [ADDR_W:0] LP_MAX = (ADDR_W+1)'(MAX_ENTRIES);

  typedef enum logic [2:0] {
    ST_LINE_START = 3'd0,
    ST_SIGNED     = 3'd1,
    ST_DIGITS     = 3'd2,
    ST_ERR        = 3'd3,
    ST_DONE       = 3'd4
  } state_t;

  // ASCII '0'..'9' test.
  function automatic logic is_digit(input logic [7:0] b);
    return (b >= LP_ZERO) && (b <= LP_NINE);
  endfunction

  // Numeric value of an ASCII digit, zero-extended to DATA_W.
  function automatic logic [DATA_W-1:0] digit_val(input logic [7:0] b);
    logic [7:0] v;
    v = b - LP_ZERO;
    return DATA_W'(v[3:0]);
  endfunction

  // mag*10 + d, wrapping modulo 2^DATA_W.
  function automatic logic [DATA_W-1:0] mul10_add(input logic [DATA_W-1:0] mag,
                                                  input logic [DATA_W-1:0] d);
    return (mag << 3) + (mag << 1) + d;
  endfunction

  // Registered state and outputs.
  state_t            r_state;
  logic              r_neg;
  logic [DATA_W-1:0] r_mag;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [ADDR_W-1:0] r_count;
  logic              r_done;
  logic              r_error;
`ifdef DAY01_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;
`endif

  // Combinational decode of the byte being consumed.
  logic              w_hs;
  state_t            w_state_p;   // state after the byte, before in_last handling
  logic              w_neg_p;
  logic [DATA_W-1:0] w_mag_p;     // magnitude after the byte, before clearing
  logic              w_commit_nl; // line terminated by '\n'
  logic              w_commit;    // any commit, including an implied one at in_last
  logic              w_last_err;
  logic              w_cap_full;
  logic              w_write;
  logic              w_err_set;
  logic [DATA_W-1:0] w_value;
  logic [DATA_W-1:0] w_mag_n;
  state_t            w_state_n;

  // A byte is taken whenever it is offered and the stream has not ended.
  assign w_hs = bus.in_valid & ~r_done;

  // Per-byte line parser; '\r' is transparent in every state.
  always_comb begin
    w_state_p   = r_state;
    w_neg_p     = r_neg;
    w_mag_p     = r_mag;
    w_commit_nl = 1'b0;
    if (w_hs && (bus.in_data != LP_CR)) begin
      case (r_state)
        ST_LINE_START: begin
          if (bus.in_data == LP_PLUS) begin
            w_neg_p   = 1'b0;
            w_state_p = ST_SIGNED;
          end else if (bus.in_data == LP_MINUS) begin
            w_neg_p   = 1'b1;
            w_state_p = ST_SIGNED;
          end else if (is_digit(bus.in_data)) begin
            w_neg_p   = 1'b0;
            w_mag_p   = digit_val(bus.in_data);
            w_state_p = ST_DIGITS;
          end else if (bus.in_data == LP_NL) begin
            w_state_p = ST_LINE_START;
          end else begin
            w_state_p = ST_ERR;
          end
        end
        ST_SIGNED: begin
          if (is_digit(bus.in_data)) begin
            w_mag_p   = digit_val(bus.in_data);
            w_state_p = ST_DIGITS;
          end else begin
            w_state_p = ST_ERR;
          end
        end
        ST_DIGITS: begin
          if (is_digit(bus.in_data)) begin
            w_mag_p   = mul10_add(r_mag, digit_val(bus.in_data));
            w_state_p = ST_DIGITS;
          end else if (bus.in_data == LP_NL) begin
            w_commit_nl = 1'b1;
            w_state_p   = ST_LINE_START;
          end else begin
            w_state_p = ST_ERR;
          end
        end
        ST_ERR: begin
          w_state_p = ST_ERR;
        end
        ST_DONE: begin
          w_state_p = ST_DONE;
        end
        default: begin
          w_state_p = ST_ERR;
        end
      endcase
    end else begin
      w_state_p = r_state;
    end
  end

  // End-of-stream handling, capacity check and next-state selection.
  always_comb begin
    w_commit   = w_commit_nl;
    w_last_err = 1'b0;
    if (w_hs && bus.in_last) begin
      // A line still collecting digits at end of file is committed as if
      // a newline had followed; a dangling sign is malformed.
      if (w_state_p == ST_DIGITS) begin
        w_commit = 1'b1;
      end else begin
        w_commit = w_commit_nl;
      end
      if (w_state_p == ST_SIGNED) begin
        w_last_err = 1'b1;
      end else begin
        w_last_err = 1'b0;
      end
    end else begin
      w_commit   = w_commit_nl;
      w_last_err = 1'b0;
    end

    w_cap_full = ({1'b0, r_count} >= LP_MAX);
    w_write    = w_commit & ~w_cap_full;
    w_err_set  = w_hs & ((w_state_p == ST_ERR) | w_last_err | (w_commit & w_cap_full));

    if (w_neg_p) begin
      w_value = {DATA_W{1'b0}} - w_mag_p;
    end else begin
      w_value = w_mag_p;
    end

    if (w_commit) begin
      w_mag_n = {DATA_W{1'b0}};
    end else begin
      w_mag_n = w_mag_p;
    end

    if (w_hs && bus.in_last) begin
      w_state_n = ST_DONE;
    end else if (w_commit && w_cap_full) begin
      w_state_n = ST_ERR;
    end else begin
      w_state_n = w_state_p;
    end
  end

  // Loader FSM with registered memory strobe, count and sticky status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_LINE_START;
      r_neg       <= 1'b0;
      r_mag       <= {DATA_W{1'b0}};
      r_mem_we    <= 1'b0;
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_count     <= {ADDR_W{1'b0}};
      r_done      <= 1'b0;
      r_error     <= 1'b0;
`ifdef DAY01_LOADER_CHECKSUM_EN
      r_checksum  <= {DATA_W{1'b0}};
`endif
    end else begin
      r_state  <= w_state_n;
      r_neg    <= w_neg_p;
      r_mag    <= w_mag_n;
      r_mem_we <= w_write;
      if (w_write) begin
        r_mem_addr  <= r_count;
        r_mem_wdata <= w_value;
        r_count     <= r_count + ADDR_W'(1);
`ifdef DAY01_LOADER_CHECKSUM_EN
        r_checksum  <= r_checksum + w_value;
`endif
      end
      r_done  <= r_done | (w_hs & bus.in_last);
      r_error <= r_error | w_err_set;
    end
  end

  assign bus.in_ready  = ~r_done;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.count     = r_count;
  assign bus.done      = r_done;
  assign bus.error     = r_error;
`ifdef DAY01_LOADER_CHECKSUM_EN
  assign bus.checksum  = r_checksum;
`endif

endmodule

// File: tb/tb_day01_loader.sv
// tb_day01_loader: directed-vector bench for day01_loader. Two instances are
// used: one at full capacity and one with MAX_ENTRIES=2 for the overflow case.
module tb_day01_loader;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 64;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [ADDR_W-1:0] q_addr_a[$];
  logic [DATA_W-1:0] q_data_a[$];
  logic [ADDR_W-1:0] q_addr_b[$];
  logic [DATA_W-1:0] q_data_b[$];
  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_data[$];

  always #5 clk = ~clk;

  day01_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  day01_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  day01_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ENTRIES(1024)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a)
  );
  day01_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_ENTRIES(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b)
  );

  // Record every write strobe, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus_a.mem_we) begin
      q_addr_a.push_back(bus_a.mem_addr);
      q_data_a.push_back(bus_a.mem_wdata);
    end
    if (bus_b.mem_we) begin
      q_addr_b.push_back(bus_b.mem_addr);
      q_data_b.push_back(bus_b.mem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input int sel, input logic [7:0] b, input logic last);
    if (sel == 0) begin
      bus_a.in_valid = 1'b1; bus_a.in_data = b; bus_a.in_last = last;
    end else begin
      bus_b.in_valid = 1'b1; bus_b.in_data = b; bus_b.in_last = last;
    end
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0; bus_a.in_last = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_last = 1'b0;
  endtask

  task automatic send_str(input int sel, input string s, input bit last);
    for (int i = 0; i < s.len(); i++) begin
      send_byte(sel, s[i], last && (i == s.len() - 1));
    end
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic clear_queues();
    q_addr_a.delete(); q_data_a.delete();
    q_addr_b.delete(); q_data_b.delete();
    exp_addr.delete(); exp_data.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_queues();
  endtask

  task automatic expect_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    exp_addr.push_back(a);
    exp_data.push_back(d);
  endtask

  // Compare captured writes of one instance against the expected list.
  task automatic check_writes(input string tag, input int sel);
    int n;
    n = (sel == 0) ? q_addr_a.size() : q_addr_b.size();
    check_eq({tag, "_nwr"}, 64'(n), 64'(exp_addr.size()));
    for (int i = 0; i < n && i < exp_addr.size(); i++) begin
      if (sel == 0) begin
        check_eq($sformatf("%s_addr%0d", tag, i), 64'(q_addr_a[i]), 64'(exp_addr[i]));
        check_eq($sformatf("%s_data%0d", tag, i), q_data_a[i], exp_data[i]);
      end else begin
        check_eq($sformatf("%s_addr%0d", tag, i), 64'(q_addr_b[i]), 64'(exp_addr[i]));
        check_eq($sformatf("%s_data%0d", tag, i), q_data_b[i], exp_data[i]);
      end
    end
  endtask

  initial begin
    bus_a.in_valid = 1'b0; bus_a.in_data = 8'h00; bus_a.in_last = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = 8'h00; bus_b.in_last = 1'b0;

    // Reset values
    #12;
    check_eq("rst_ready",  64'(bus_a.in_ready),  64'd1);
    check_eq("rst_we",     64'(bus_a.mem_we),    64'd0);
    check_eq("rst_addr",   64'(bus_a.mem_addr),  64'd0);
    check_eq("rst_wdata",  bus_a.mem_wdata,      64'd0);
    check_eq("rst_count",  64'(bus_a.count),     64'd0);
    check_eq("rst_done",   64'(bus_a.done),      64'd0);
    check_eq("rst_error",  64'(bus_a.error),     64'd0);
`ifdef DAY01_LOADER_CHECKSUM_EN
    check_eq("rst_csum",   bus_a.checksum,       64'd0);
`endif
    do_reset();

    // Test 1: basic four-line stream, with one-cycle commit latency check
    send_str(0, "+1\n", 1'b0);
    check_eq("t1_lat_we",    64'(bus_a.mem_we),   64'd1);
    check_eq("t1_lat_addr",  64'(bus_a.mem_addr), 64'd0);
    check_eq("t1_lat_data",  bus_a.mem_wdata,     64'd1);
    check_eq("t1_lat_count", 64'(bus_a.count),    64'd1);
    send_str(0, "-2\n+3\n+1\n", 1'b1);
    idle();
    expect_write(16'd0, 64'd1);
    expect_write(16'd1, 64'hFFFF_FFFF_FFFF_FFFE);
    expect_write(16'd2, 64'd3);
    expect_write(16'd3, 64'd1);
    check_writes("t1", 0);
    check_eq("t1_count", 64'(bus_a.count),    64'd4);
    check_eq("t1_done",  64'(bus_a.done),     64'd1);
    check_eq("t1_error", 64'(bus_a.error),    64'd0);
    check_eq("t1_ready", 64'(bus_a.in_ready), 64'd0);
`ifdef DAY01_LOADER_CHECKSUM_EN
    check_eq("t1_csum",  bus_a.checksum,      64'd3);
`endif

    // Test 2: CR, blank line, no trailing newline
    do_reset();
    send_str(0, "+12\r\n\n-345", 1'b1);
    check_eq("t2_done_with_count", 64'(bus_a.count), 64'd2);
    idle();
    expect_write(16'd0, 64'd12);
    expect_write(16'd1, 64'hFFFF_FFFF_FFFF_FEA7);
    check_writes("t2", 0);
    check_eq("t2_done",  64'(bus_a.done),  64'd1);
    check_eq("t2_error", 64'(bus_a.error), 64'd0);
`ifdef DAY01_LOADER_CHECKSUM_EN
    check_eq("t2_csum",  bus_a.checksum,   64'hFFFF_FFFF_FFFF_FEB3);
`endif

    // Test 3: bad character mid-stream
    do_reset();
    send_str(0, "+7\n+", 1'b0);
    check_eq("t3_err_before", 64'(bus_a.error), 64'd0);
    send_byte(0, 8'h78, 1'b0);
    check_eq("t3_err_x",  64'(bus_a.error), 64'd1);
    send_str(0, "\n-1\n", 1'b1);
    idle();
    expect_write(16'd0, 64'd7);
    check_writes("t3", 0);
    check_eq("t3_count", 64'(bus_a.count), 64'd1);
    check_eq("t3_done",  64'(bus_a.done),  64'd1);
    check_eq("t3_error", 64'(bus_a.error), 64'd1);

    // Test 4: sign with no digits
    do_reset();
    send_str(0, "-\n", 1'b0);
    check_eq("t4_err_nl",  64'(bus_a.error), 64'd1);
    check_eq("t4_done_no", 64'(bus_a.done),  64'd0);
    send_byte(0, 8'h41, 1'b1);
    idle();
    check_writes("t4", 0);
    check_eq("t4_done",  64'(bus_a.done),  64'd1);
    check_eq("t4_count", 64'(bus_a.count), 64'd0);

    // Test 5: capacity overflow on the two-entry instance
    do_reset();
    send_str(1, "+1\n+2\n+3", 1'b0);
    check_eq("t5_err_before", 64'(bus_b.error), 64'd0);
    send_byte(1, 8'h0A, 1'b1);
    check_eq("t5_err",   64'(bus_b.error), 64'd1);
    check_eq("t5_done",  64'(bus_b.done),  64'd1);
    idle();
    expect_write(16'd0, 64'd1);
    expect_write(16'd1, 64'd2);
    check_writes("t5", 1);
    check_eq("t5_count", 64'(bus_b.count), 64'd2);

    // Test 6: async reset mid-stream drops a pending write
    do_reset();
    send_str(0, "+1\n+2\n+3\n", 1'b0);
    check_eq("t6_pending", 64'(bus_a.mem_we), 64'd1);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_we",    64'(bus_a.mem_we),   64'd0);
    check_eq("t6_rst_addr",  64'(bus_a.mem_addr), 64'd0);
    check_eq("t6_rst_wdata", bus_a.mem_wdata,     64'd0);
    check_eq("t6_rst_count", 64'(bus_a.count),    64'd0);
    check_eq("t6_rst_error", 64'(bus_a.error),    64'd0);
    check_eq("t6_rst_ready", 64'(bus_a.in_ready), 64'd1);
`ifdef DAY01_LOADER_CHECKSUM_EN
    check_eq("t6_rst_csum",  bus_a.checksum,      64'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_queues();
    send_str(0, "+5\n", 1'b1);
    idle();
    expect_write(16'd0, 64'd5);
    check_writes("t6", 0);
    check_eq("t6_count", 64'(bus_a.count), 64'd1);
    check_eq("t6_done",  64'(bus_a.done),  64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
